// File: rtl/multu_unit_if.sv
// Issue/result bundle between the execute-stage control and the iterative
// unsigned multiplier (HI/LO owner).
interface multu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       ALUctrl;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUctrl, srcA, srcB,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, ALUctrl, srcA, srcB,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/multu_unit.sv
// Iterative shift-add unsigned multiplier owning HI/LO, one step per clock.
// Optional MULT_ZERO_BYPASS_EN: zero operands finish at the accept edge.
module multu_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [5:0] MULT_CODE = 6'h13
) (
    input  logic         clk,
    input  logic         reset,
    multu_unit_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [2*WIDTH-1:0]   p_r;
    logic [2*WIDTH-1:0]   p_step_s;
    logic [WIDTH:0]       sum_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 accept_s;
    logic                 last_s;
    logic                 zero_s;

    // A start in RUN is dropped; DONE may accept so back-to-back issues have no gap.
    assign accept_s = bus.start && (bus.ALUctrl == MULT_CODE) && (state_r != RUN);
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_s = (bus.srcA == {WIDTH{1'b0}}) || (bus.srcB == {WIDTH{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    // One shift-add step; the extra sum bit carries into the shifted product.
    always_comb begin
        sum_s    = {1'b0, p_r[2*WIDTH-1:WIDTH]}
                 + (p_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        p_step_s = {sum_s, p_r[WIDTH-1:1]};
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = zero_s ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered busy/done status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand, product, counter and HI/LO registers; HI/LO only change on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r <= {WIDTH{1'b0}};
            p_r     <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            mcand_r <= bus.srcA;
            p_r     <= {{WIDTH{1'b0}}, bus.srcB};
            cnt_r   <= {CNT_W{1'b0}};
            if (zero_s) begin
                hi_r <= {WIDTH{1'b0}};
                lo_r <= {WIDTH{1'b0}};
            end
        end else if (state_r == RUN) begin
            p_r   <= p_step_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_s) begin
                hi_r <= p_step_s[2*WIDTH-1:WIDTH];
                lo_r <= p_step_s[WIDTH-1:0];
            end
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_multu_unit.sv
// Directed self-checking bench for multu_unit: latency, HI/LO results,
// ignored issues, back-to-back accept and asynchronous reset mid-run.
module tb_multu_unit;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    multu_unit_if #(.WIDTH(32)) bus ();

    multu_unit #(.WIDTH(32), .MULT_CODE(6'h13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; issues a multiply and checks latency and result.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
        int n;
        bus.start   = 1'b1;
        bus.ALUctrl = 6'h13;
        bus.srcA    = a;
        bus.srcB    = b;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.ALUctrl = 6'h00;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int n;
        n_tests     = 0;
        n_fail      = 0;
        clk         = 1'b0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.ALUctrl = 6'h00;
        bus.srcA    = 32'h0;
        bus.srcB    = 32'h0;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001, "max");
        do_mul(32'h0001_E240, 32'h0000_0001, 32, 32'h0000_0000, 32'h0001_E240, "one");

        // Start with a non-multiply code is ignored
        bus.start   = 1'b1;
        bus.ALUctrl = 6'h02;
        bus.srcA    = 32'd5;
        bus.srcB    = 32'd7;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        chk("badcode_busy", 64'(bus.busy), 64'd0);
        chk("badcode_done", 64'(bus.done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("badcode_busy_late", 64'(bus.busy), 64'd0);
        chk("badcode_hi", 64'(bus.hi), 64'd0);
        chk("badcode_lo", 64'(bus.lo), 64'h0001_E240);

        // 0x10000 x 0x10000 with an ignored re-issue during RUN
        bus.start   = 1'b1;
        bus.ALUctrl = 6'h13;
        bus.srcA    = 32'h0001_0000;
        bus.srcB    = 32'h0001_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 5) begin
                bus.start = 1'b1;
                bus.srcA  = 32'd3;
                bus.srcB  = 32'd4;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("run_ign_busy_cycles", 64'(n), 64'd32);
        chk("run_ign_done", 64'(bus.done), 64'd1);
        chk("run_ign_hi", 64'(bus.hi), 64'h1);
        chk("run_ign_lo", 64'(bus.lo), 64'h0);

        // Back-to-back accept in the DONE cycle
        bus.start   = 1'b1;
        bus.ALUctrl = 6'h13;
        bus.srcA    = 32'd3;
        bus.srcB    = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_nogap_busy", 64'(bus.busy), 64'd1);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("b2b_busy_cycles", 64'(n), 64'd32);
        chk("b2b_done", 64'(bus.done), 64'd1);
        chk("b2b_hi", 64'(bus.hi), 64'h0);
        chk("b2b_lo", 64'(bus.lo), 64'hC);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a run
        bus.start   = 1'b1;
        bus.ALUctrl = 6'h13;
        bus.srcA    = 32'hDEAD_BEEF;
        bus.srcB    = 32'h0000_0002;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        do_mul(32'd7, 32'd6, 32, 32'h0, 32'h2A, "after_rst");

        // Zero operand: bypass or full-length run depending on build
`ifdef MULT_ZERO_BYPASS_EN
        do_mul(32'h0000_1234, 32'h0, 0, 32'h0, 32'h0, "zero");
`else
        do_mul(32'h0000_1234, 32'h0, 32, 32'h0, 32'h0, "zero");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
